// File: rtl/clock_divider_prog.sv
// Run-time programmable integer clock divider (even and odd divisors) with
// boundary-aligned divisor loads and a divided-domain reset. Optional falling-edge
// enable port o_ce_fall is enabled by defining CLOCK_DIVIDER_FALL_CE_EN.
module clock_divider_prog #(
   parameter int par_div_width   = 16,
   parameter int par_div_default = 1000,
   parameter int par_rst_periods = 1
) (
   input  logic                     i_clk_mhz,
   input  logic                     i_rst_mhz,
   input  logic                     i_div_valid,
   input  logic [par_div_width-1:0] i_div_value,
   output logic                     o_div_ready,
   output logic                     o_div_err,
   output logic                     o_clk_div,
   output logic                     o_ce_rise,
`ifdef CLOCK_DIVIDER_FALL_CE_EN
   output logic                     o_ce_fall,
`endif
   output logic                     o_rst_div
);

   localparam logic [par_div_width-1:0] div_min  = par_div_width'(2);
   localparam logic [par_div_width-1:0] div_init = par_div_width'(par_div_default);
   localparam logic [7:0]               rst_last = 8'(par_rst_periods - 1);

   logic [par_div_width-1:0] cnt, cnt_next;
   logic [par_div_width-1:0] d_act, d_next, d_pend, h_next;
   logic                     pend_valid, pend_valid_next;
   logic                     run;
   logic [7:0]               per_cnt;
   logic                     wrap, swap, xfer, value_ok, fall_next;

   // All registered outputs are computed from the next counter value so they
   // line up with cnt in the cycle they are visible.
   always_comb begin
      wrap      = run && (cnt == d_act - 1'b1);
      swap      = wrap && pend_valid;
      d_next    = swap ? d_pend : d_act;
      h_next    = d_next >> 1;
      cnt_next  = (!run || wrap) ? '0 : cnt + 1'b1;
      fall_next = run && (cnt_next == h_next);
      xfer      = i_div_valid && o_div_ready;
      value_ok  = (i_div_value >= div_min);
      pend_valid_next = pend_valid;
      if (xfer && value_ok) begin
         pend_valid_next = 1'b1;
      end else if (swap) begin
         pend_valid_next = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values computed above.
   always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
      if (i_rst_mhz) begin
         cnt         <= '0;
         d_act       <= div_init;
         d_pend      <= '0;
         pend_valid  <= 1'b0;
         run         <= 1'b0;
         per_cnt     <= '0;
         o_div_ready <= 1'b0;
         o_div_err   <= 1'b0;
         o_clk_div   <= 1'b0;
         o_ce_rise   <= 1'b0;
         o_rst_div   <= 1'b1;
`ifdef CLOCK_DIVIDER_FALL_CE_EN
         o_ce_fall   <= 1'b0;
`endif
      end else begin
         run         <= 1'b1;
         cnt         <= cnt_next;
         d_act       <= d_next;
         pend_valid  <= pend_valid_next;
         o_div_ready <= !pend_valid_next;
         o_div_err   <= xfer && !value_ok;
         o_clk_div   <= (cnt_next < h_next);
         o_ce_rise   <= (cnt_next == '0);
`ifdef CLOCK_DIVIDER_FALL_CE_EN
         o_ce_fall   <= fall_next;
`endif
         if (xfer && value_ok) begin
            d_pend <= i_div_value;
         end
         // Reset release tracks completed high phases; it never restarts on a divisor change.
         if (fall_next && o_rst_div) begin
            per_cnt <= per_cnt + 1'b1;
            if (per_cnt == rst_last) begin
               o_rst_div <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed self-checking bench for clock_divider_prog: default-divisor instance
// plus a D=2 / three-period-reset instance sharing the clock and reset.
module tb_clock_divider_prog;

   logic        clk = 1'b0;
   logic        rst;
   logic        div_valid;
   logic [15:0] div_value;
   logic        ready, err, clk_div, ce_rise, rst_div, ce_fall;
   logic        div_valid2;
   logic [15:0] div_value2;
   logic        ready2, err2, clk_div2, ce_rise2, rst_div2, ce_fall2;

   int n_assert = 0;
   int n_fail   = 0;
   int d, ph;

   always #5 clk = ~clk;

   clock_divider_prog u_dut (
      .i_clk_mhz   (clk),
      .i_rst_mhz   (rst),
      .i_div_valid (div_valid),
      .i_div_value (div_value),
      .o_div_ready (ready),
      .o_div_err   (err),
      .o_clk_div   (clk_div),
      .o_ce_rise   (ce_rise),
`ifdef CLOCK_DIVIDER_FALL_CE_EN
      .o_ce_fall   (ce_fall),
`endif
      .o_rst_div   (rst_div)
   );

   clock_divider_prog #(.par_div_default(2), .par_rst_periods(3)) u_dut2 (
      .i_clk_mhz   (clk),
      .i_rst_mhz   (rst),
      .i_div_valid (div_valid2),
      .i_div_value (div_value2),
      .o_div_ready (ready2),
      .o_div_err   (err2),
      .o_clk_div   (clk_div2),
      .o_ce_rise   (ce_rise2),
`ifdef CLOCK_DIVIDER_FALL_CE_EN
      .o_ce_fall   (ce_fall2),
`endif
      .o_rst_div   (rst_div2)
   );

`ifndef CLOCK_DIVIDER_FALL_CE_EN
   assign ce_fall  = 1'b0;
   assign ce_fall2 = 1'b0;
`endif

   task automatic check(input string tag, input int cyc, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check_reset_values(input int cyc);
      check("rst_clk_div", cyc, clk_div, 1'b0);
      check("rst_ce_rise", cyc, ce_rise, 1'b0);
      check("rst_rst_div", cyc, rst_div, 1'b1);
      check("rst_ready", cyc, ready, 1'b0);
      check("rst_err", cyc, err, 1'b0);
      check("rst_ce_fall", cyc, ce_fall, 1'b0);
      check("rst_clk_div2", cyc, clk_div2, 1'b0);
      check("rst_rst_div2", cyc, rst_div2, 1'b1);
      check("rst_ready2", cyc, ready2, 1'b0);
   endtask

   initial begin
      rst        = 1'b1;
      div_valid  = 1'b0;
      div_value  = '0;
      div_valid2 = 1'b0;
      div_value2 = '0;
      tick();
      tick();
      check_reset_values(-1);
      rst = 1'b0;

      // Default D=1000; D=7 loaded at cycle 300; bad divisors 1 and 0; D=4 offered on a wrap.
      for (int c = 0; c <= 1070; c++) begin
         tick();
         if (c < 1000) begin
            d = 1000; ph = c;
         end else if (c < 1049) begin
            d = 7; ph = (c - 1000) % 7;
         end else begin
            d = 4; ph = (c - 1049) % 4;
         end
         check("clk_div", c, clk_div, ph < d / 2);
         check("ce_rise", c, ce_rise, ph == 0);
         check("rst_div", c, rst_div, c < 500);
         check("ready", c, ready, !((c >= 301 && c <= 999) || (c >= 1042 && c <= 1048)));
         check("div_err", c, err, (c == 1011) || (c == 1013));
`ifdef CLOCK_DIVIDER_FALL_CE_EN
         check("ce_fall", c, ce_fall, ph == d / 2);
`endif
         if (c < 12) begin
            check("clk_div2", c, clk_div2, (c % 2) == 0);
            check("ce_rise2", c, ce_rise2, (c % 2) == 0);
            check("rst_div2", c, rst_div2, c < 5);
         end
         div_valid = 1'b0;
         case (c)
            300:  begin div_valid = 1'b1; div_value = 16'd7; end
            1010: begin div_valid = 1'b1; div_value = 16'd1; end
            1012: begin div_valid = 1'b1; div_value = 16'd0; end
            1041: begin div_valid = 1'b1; div_value = 16'd4; end
            default: ;
         endcase
      end

      // Leave D=9 pending, then reset asynchronously mid-cycle.
      div_valid = 1'b1;
      div_value = 16'd9;
      tick();
      div_valid = 1'b0;
      check("pending_taken", 1071, ready, 1'b0);
      #1 rst = 1'b1;
      #1 check_reset_values(1071);
      tick();
      rst = 1'b0;

      // After reset the default divisor is back and the discarded D=9 never applies.
      for (int c = 0; c <= 1010; c++) begin
         tick();
         check("re_clk_div", c, clk_div, (c % 1000) < 500);
         check("re_ce_rise", c, ce_rise, (c % 1000) == 0);
         check("re_ready", c, ready, 1'b1);
         check("re_rst_div", c, rst_div, c < 500);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
